// File: rtl/aud_pkg.sv
// Shared definitions for the I2S audio player.
// Contents: PCM word width, bit-counter width, load value for the
// bit counter, and the player state encoding.
// Build option: define AUD_PLAYER_DUP_EN to re-serialise the left sample
// into the right half-frame. Without it, the right half-frame stays silent.
package aud_pkg;

  localparam int AUD_WORD_W = 16;
  localparam int AUD_CNT_W  = 4;

  // Bit index of the MSB, loaded into the counter at the start of every word.
  localparam logic [AUD_CNT_W-1:0] AUD_CNT_MAX = AUD_CNT_W'(AUD_WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // disabled
    S_WAIT = 2'd1,  // armed, waiting for the first LRCK fall
    S_SEND = 2'd2,  // shifting a word out
    S_HOLD = 2'd3   // word finished, driving 0
  } aud_state_t;

endpackage

// File: rtl/aud_lrck_edge.sv
// LRCK edge detector for the I2S audio player.
// Registers the codec DAC LR clock once per BCLK and compares the previous
// and current values to produce single-cycle edge strobes.
// Ports:
//   i_clk     codec BCLK
//   i_rst_n   asynchronous active-low reset
//   i_daclrck codec DAC LR clock (0 = left, 1 = right)
//   o_fall    left half-frame starts (previous 1, now 0)
//   o_rise    right half-frame starts (previous 0, now 1)
module aud_lrck_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_daclrck,
  output logic o_fall,
  output logic o_rise
);

  logic lrck_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrck_prev <= 1'b0;
    end else begin
      lrck_prev <= i_daclrck;
    end
  end

  assign o_fall = lrck_prev & ~i_daclrck;
  assign o_rise = ~lrck_prev & i_daclrck;

endmodule

// File: rtl/aud_i2s_player.sv
// I2S audio player: serialises 16-bit signed PCM samples to the codec,
// MSB first, one bit per BCLK.
// A left word is latched on each LRCK fall. The first bit appears in the
// cycle after the edge is detected, and the remaining 15 bits follow on
// consecutive cycles. An LRCK edge during a word aborts that word. Dropping
// i_en forces the output to 0 at once and returns the player to idle.
// Build option: AUD_PLAYER_DUP_EN. When defined, each LRCK rise replays the
// last left sample for the right channel. When undefined, the right
// half-frame stays 0 and produces no o_word_done.
// Ports:
//   i_clk         codec BCLK (rising edge)
//   i_rst_n       asynchronous active-low reset
//   i_en          player enable from the upstream DSP
//   i_daclrck     codec DAC LR clock (0 = left, 1 = right)
//   i_dac_data    signed PCM sample from the upstream DSP
//   o_aud_dacdat  serial data to the codec
//   o_word_done   one-cycle pulse after the last bit of a completed word
//   o_underrun    sticky: a left frame started with i_en low after playback
//                 had begun
module aud_i2s_player
  import aud_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_daclrck,
  input  logic [AUD_WORD_W-1:0] i_dac_data,
  output logic                  o_aud_dacdat,
  output logic                  o_word_done,
  output logic                  o_underrun
);

  logic                  fall;
  logic                  rise;
  aud_state_t            state;
  logic [AUD_WORD_W-1:0] shift_r;
  logic [AUD_CNT_W-1:0]  cnt;
  logic                  sent_any;

  aud_lrck_edge u_edge (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_daclrck (i_daclrck),
    .o_fall    (fall),
    .o_rise    (rise)
  );

  // shift_r keeps the whole latched sample for the length of the word.
  // The outgoing bit is selected by the counter, so the sample is still
  // available when the right channel replays it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      shift_r      <= '0;
      cnt          <= '0;
      sent_any     <= 1'b0;
      o_aud_dacdat <= 1'b0;
      o_word_done  <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      o_word_done <= 1'b0;

      if (fall && !i_en && sent_any) begin
        o_underrun <= 1'b1;
      end

      if (!i_en) begin
        state        <= S_IDLE;
        o_aud_dacdat <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_WAIT;
          end
          default: begin
            if (fall) begin
              shift_r      <= i_dac_data;
              cnt          <= AUD_CNT_MAX;
              o_aud_dacdat <= i_dac_data[AUD_WORD_W-1];
              state        <= S_SEND;
            end else if (rise && state != S_WAIT) begin
              // Nothing has been latched in S_WAIT, so a rise there is ignored.
`ifdef AUD_PLAYER_DUP_EN
              cnt          <= AUD_CNT_MAX;
              o_aud_dacdat <= shift_r[AUD_WORD_W-1];
              state        <= S_SEND;
`else
              o_aud_dacdat <= 1'b0;
              state        <= S_HOLD;
`endif
            end else if (state == S_SEND) begin
              if (cnt == '0) begin
                o_aud_dacdat <= 1'b0;
                o_word_done  <= 1'b1;
                sent_any     <= 1'b1;
                state        <= S_HOLD;
              end else begin
                o_aud_dacdat <= shift_r[cnt - 1'b1];
                cnt          <= cnt - 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aud_i2s_player.sv
// Directed testbench for aud_i2s_player.
// Covers the reset state, left-word serialisation, the right half-frame in
// both builds (AUD_PLAYER_DUP_EN defined or undefined), abort on a new LRCK
// edge, disable mid-word, the sticky underrun flag, and asynchronous reset
// applied mid-word.
module tb_aud_i2s_player;
  import aud_pkg::*;

`ifdef AUD_PLAYER_DUP_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        lrck  = 1'b1;
  logic [15:0] data  = 16'h0000;
  logic        dacdat;
  logic        word_done;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aud_i2s_player dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_daclrck    (lrck),
    .i_dac_data   (data),
    .o_aud_dacdat (dacdat),
    .o_word_done  (word_done),
    .o_underrun   (underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // LRCK fall, then 16 data bits, one done pulse, and a quiet cycle (18 ticks).
  task automatic left_word(input logic [15:0] d, input string tag);
    data = d;
    lrck = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      tick();
      chk({tag, "_bit"}, 32'(dacdat), 32'(d[i]));
      chk({tag, "_done_low"}, 32'(word_done), 32'd0);
    end
    tick();
    chk({tag, "_done"}, 32'(word_done), 32'd1);
    chk({tag, "_after_zero"}, 32'(dacdat), 32'd0);
    tick();
    chk({tag, "_done_once"}, 32'(word_done), 32'd0);
  endtask

  // LRCK rise, then 16 right-channel bits, and the done slot (18 ticks).
  task automatic right_half(input logic [15:0] d, input string tag);
    lrck = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      tick();
      chk({tag, "_rbit"}, 32'(dacdat), DUP ? 32'(d[i]) : 32'd0);
    end
    tick();
    chk({tag, "_rdone"}, 32'(word_done), 32'(DUP));
    tick();
    chk({tag, "_rdone_once"}, 32'(word_done), 32'd0);
  endtask

  // One full LRCK period of 64 BCLK.
  task automatic frame(input logic [15:0] d, input string tag);
    left_word(d, tag);
    tick(14);
    right_half(d, tag);
    tick(14);
  endtask

  logic [15:0] old_w;
  int          done_cnt;

  initial begin
    // Reset state
    #2;
    chk("rst_dacdat", 32'(dacdat), 32'd0);
    chk("rst_done", 32'(word_done), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(S_IDLE));
    tick(3);
    chk("rst_hold_dacdat", 32'(dacdat), 32'd0);

    // Arm the player: IDLE -> WAIT; LRCK high so the next fall is clean.
    rst_n = 1'b1;
    en    = 1'b1;
    tick(2);
    chk("armed_state", 32'(dut.state), 32'(S_WAIT));

    // Left serialisation and the right half-frame
    frame(16'hA5C3, "a5c3");
    frame(16'h8001, "8001");

    // Abort: a new fall 8 bits into a word. LRCK must be high for one edge
    // in between, which the player sees as a rise.
    old_w = 16'hA500;
    data  = old_w;
    lrck  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("abort_old_bit", 32'(dacdat), 32'(old_w[15 - k]));
    end
    lrck = 1'b1;
    tick();
    chk("abort_glitch", 32'(dacdat), DUP ? 32'd1 : 32'd0);
    chk("abort_glitch_done", 32'(word_done), 32'd0);
    lrck     = 1'b0;
    data     = 16'hFFFF;
    done_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      done_cnt += int'(word_done);
      chk("abort_new_bit", 32'(dacdat), 32'd1);
    end
    tick();
    done_cnt += int'(word_done);
    chk("abort_done", 32'(word_done), 32'd1);
    tick();
    done_cnt += int'(word_done);
    chk("abort_done_count", 32'(done_cnt), 32'd1);
    tick(12);
    right_half(16'hFFFF, "abort");
    tick(14);

    // Disable mid-word: drop i_en while bit 10 is on the line.
    data = 16'hC3C3;
    lrck = 1'b0;
    old_w = 16'hC3C3;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("dis_bit", 32'(dacdat), 32'(old_w[15 - k]));
    end
    en = 1'b0;
    tick();
    chk("dis_dacdat", 32'(dacdat), 32'd0);
    chk("dis_state", 32'(dut.state), 32'(S_IDLE));
    chk("dis_done", 32'(word_done), 32'd0);
    chk("dis_underrun", 32'(underrun), 32'd0);
    tick(3);
    chk("dis_done_late", 32'(word_done), 32'd0);
    lrck = 1'b1;
    tick(4);
    chk("dis_underrun_late", 32'(underrun), 32'd0);

    // Underrun: a fall while disabled, after words have already been sent.
    en = 1'b1;
    tick(2);
    en   = 1'b0;
    lrck = 1'b0;
    tick();
    chk("underrun_set", 32'(underrun), 32'd1);
    tick();
    en   = 1'b1;
    lrck = 1'b1;
    tick(2);
    frame(16'h5A5A, "5a5a");
    chk("underrun_sticky", 32'(underrun), 32'd1);

    // Asynchronous reset mid-word
    data = 16'hFFFF;
    lrck = 1'b0;
    tick(3);
    chk("arst_pre_bit", 32'(dacdat), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dacdat", 32'(dacdat), 32'd0);
    chk("arst_done", 32'(word_done), 32'd0);
    chk("arst_underrun", 32'(underrun), 32'd0);
    chk("arst_state", 32'(dut.state), 32'(S_IDLE));
    tick(2);
    rst_n = 1'b1;
    en    = 1'b1;
    tick(3);
    chk("arst_no_word_low", 32'(dacdat), 32'd0);
    lrck = 1'b1;
    tick(2);
    chk("arst_no_word_rise", 32'(dacdat), 32'd0);
    left_word(16'h3C96, "3c96");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aud_i2s_player.md
AUD_I2S_PLAYER -- requirements
Module: aud_i2s_player

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named i_clk and i_rst_n.
REQ-002 Port: i_clk  in  1  codec BCLK; all logic samples on its rising edge.
REQ-003 Port: i_rst_n  in  1  asynchronous active-low reset.
REQ-004 Port: i_en  in  1  player enable, driven by the upstream DSP player-enable output.
REQ-005 Port: i_daclrck  in  1  codec DAC LR clock; 0 = left half-frame, 1 = right half-frame.
REQ-006 Port: i_dac_data  in  16  signed PCM sample, driven by the upstream DSP DAC-data output.
REQ-007 Port: o_aud_dacdat  out  1  serial data to the codec, MSB first.
REQ-008 Port: o_word_done  out  1  one-cycle pulse after the last bit of any transmitted word.
REQ-009 Port: o_underrun  out  1  sticky flag: a left-channel frame started while i_en was low after playback had begun.

Function
REQ-010 SHALL register i_daclrck each cycle into lrck_prev; fall = prev 1 and now 0; rise = prev 0 and now 1.
REQ-011 States SHALL be: S_IDLE, S_WAIT (armed, awaiting edge), S_SEND (shifting), S_HOLD (word finished, driving 0).
REQ-012 S_IDLE -> S_WAIT when i_en = 1; no data is latched in S_IDLE.
REQ-013 In S_WAIT/S_HOLD with i_en = 1, a fall SHALL latch i_dac_data into shift_r, load bit counter = 15, and go to S_SEND.
REQ-014 Latency: o_aud_dacdat SHALL show bit 15 in the cycle after the detecting edge, then bits 14..0 on the next 15 cycles.
REQ-015 After bit 0, o_word_done SHALL pulse for exactly one cycle, state SHALL go to S_HOLD, and o_aud_dacdat SHALL be 0 until the next word.
REQ-016 Right half-frame (rise) behaviour SHALL follow the AUD_PLAYER_DUP_EN rules in the Configuration section.
REQ-017 An edge arriving in S_SEND SHALL abort the current word and restart per REQ-013 or REQ-016; o_word_done SHALL NOT pulse for the aborted word.
REQ-018 i_en falling in any state SHALL force o_aud_dacdat = 0 on the next cycle and state = S_IDLE, with the word aborted and no o_word_done.
REQ-019 A fall with i_en = 0 after at least one word has been sent since reset SHALL set o_underrun; only reset clears it.
REQ-020 Bit counter: 4-bit down-counter, no wrap; 0 -> S_HOLD.
REQ-021 Data SHALL be passed bit-exact, with no sign manipulation or arithmetic.

Reset
REQ-022 While i_rst_n = 0: state = S_IDLE, shift_r = 0, counter = 0, lrck_prev = 0, o_aud_dacdat = 0, o_word_done = 0, o_underrun = 0.
REQ-023 Reset asserted mid-word SHALL drive o_aud_dacdat to 0 immediately, asynchronously.
REQ-024 After reset release, the first word SHALL start only on a fall detected after i_en = 1.

Configuration
REQ-025 Macro AUD_PLAYER_DUP_EN defined: on a rise in S_HOLD with i_en = 1, the last left sample SHALL be re-serialised for the right channel, with identical timing.
REQ-026 Macro AUD_PLAYER_DUP_EN undefined: the right half-frame SHALL output constant 0 and o_word_done SHALL NOT pulse.

Structure
REQ-027 Package aud_pkg SHALL hold: localparam AUD_WORD_W = 16, the state enum, and the bit-counter width.
REQ-028 Sub-module aud_lrck_edge SHALL register i_daclrck and output the fall and rise pulses; all other logic SHALL live in aud_i2s_player.

Verification
REQ-029 Left serialisation: i_en = 1, i_dac_data = 16'hA5C3, LRCK fall -> next 16 cycles o_aud_dacdat = 1010010111000011, o_word_done pulses on cycle 17, then 0.
REQ-030 DUP on/off: data 16'h8001, LRCK period 64 BCLK -> with macro, right half = 1000000000000001; without macro, right half = all 0.
REQ-031 Abort on edge: LRCK fall re-issued 8 cycles into a word with new data 16'hFFFF -> 8 old bits, then 16 ones, and exactly one o_word_done.
REQ-032 Disable mid-word: i_en dropped at bit 10 -> o_aud_dacdat = 0 next cycle, state S_IDLE, no o_word_done, o_underrun stays 0.
REQ-033 Underrun: one word sent, i_en = 0 at the next fall -> o_underrun = 1 and it stays 1 through later valid words until reset.
REQ-034 Async reset mid-word: i_rst_n low between clock edges -> all outputs 0 without a clock; after release with i_en = 1, no output until the first fall.
